// File: rtl/sevenseg_arbiter.sv
// Round-robin owner of the shared seven-segment driver. Grants one of four clients at a time,
// holds each grant for a minimum dwell, and blanks the display between owners.
module sevenseg_arbiter #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int BLANK_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] req_din,
  input  logic [3:0]  req_bcd,
  input  logic [7:0]  req_dec,
  output logic [3:0]  gnt,
  output logic [1:0]  cur_id,
  output logic [15:0] din,
  output logic        bcd,
  output logic [1:0]  dec,
  output logic        enable
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dwell_cnt, dwell_cnt_nx;
  logic [BW-1:0] blank_cnt, blank_cnt_nx;
  logic [3:0]    gnt_nx;
  logic [1:0]    id_nx;
  logic [15:0]   din_nx;
  logic          bcd_nx;
  logic [1:0]    dec_nx;
  logic          en_nx;
  logic [1:0]    winner;
  logic          any_req;
  logic          others_req;
  logic          grant_now;

  assign any_req    = |req;
  assign others_req = |(req & ~(4'b0001 << cur_id));

  // Walk the search order backwards so the earliest candidate (cur_id+1) overwrites last.
  always_comb begin
    winner = cur_id;
    for (int k = 4; k >= 1; k--) begin
      if (req[cur_id + 2'(k)]) winner = cur_id + 2'(k);
    end
  end

  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    id_nx        = cur_id;
    din_nx       = din;
    bcd_nx       = bcd;
    dec_nx       = dec;
    en_nx        = enable;
    dwell_cnt_nx = dwell_cnt;
    blank_cnt_nx = blank_cnt;
    grant_now    = 1'b0;
    case (state)
      IDLE: grant_now = any_req;
      SHOW: begin
        // Saturating at DWELL_LAST keeps "dwell expired" sticky without a separate flag.
        if (dwell_cnt != DWELL_LAST) dwell_cnt_nx = dwell_cnt + 1'b1;
        if (!req[cur_id] || (dwell_cnt == DWELL_LAST && others_req)) begin
          state_nx     = BLANK;
          gnt_nx       = 4'b0000;
          en_nx        = 1'b0;
          blank_cnt_nx = '0;
        end else begin
          din_nx = req_din[{cur_id, 4'h0} +: 16];
          bcd_nx = req_bcd[cur_id];
          dec_nx = req_dec[{cur_id, 1'b0} +: 2];
        end
      end
      BLANK: begin
        blank_cnt_nx = blank_cnt + 1'b1;
        if (blank_cnt == BLANK_LAST) begin
          if (any_req) grant_now = 1'b1;
          else         state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (grant_now) begin
      state_nx     = SHOW;
      gnt_nx       = 4'b0001 << winner;
      id_nx        = winner;
      en_nx        = 1'b1;
      dwell_cnt_nx = '0;
      din_nx       = req_din[{winner, 4'h0} +: 16];
      bcd_nx       = req_bcd[winner];
      dec_nx       = req_dec[{winner, 1'b0} +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      cur_id    <= 2'd3;
      din       <= 16'h0000;
      bcd       <= 1'b1;
      dec       <= 2'd0;
      enable    <= 1'b0;
      dwell_cnt <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      cur_id    <= id_nx;
      din       <= din_nx;
      bcd       <= bcd_nx;
      dec       <= dec_nx;
      enable    <= en_nx;
      dwell_cnt <= dwell_cnt_nx;
      blank_cnt <= blank_cnt_nx;
    end
  end

endmodule

// File: tb/tb_sevenseg_arbiter.sv
// Directed and randomized bench for sevenseg_arbiter; every edge is compared against
// a behavioural model that tracks owner, cycles held and blank cycles remaining.
module tb_sevenseg_arbiter;

  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_din;
  logic [3:0]  req_bcd;
  logic [7:0]  req_dec;
  logic [3:0]  gnt;
  logic [1:0]  cur_id;
  logic [15:0] din;
  logic        bcd;
  logic [1:0]  dec;
  logic        enable;

  always #5 clk = ~clk;

  sevenseg_arbiter #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .req(req), .req_din(req_din), .req_bcd(req_bcd),
    .req_dec(req_dec), .gnt(gnt), .cur_id(cur_id), .din(din), .bcd(bcd),
    .dec(dec), .enable(enable)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0]  m_gnt;
  logic [1:0]  m_id;
  logic [15:0] m_din;
  logic        m_bcd;
  logic [1:0]  m_dec;
  logic        m_en;
  int          held;
  int          blank_left;

  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(int'(last) + k) % 4]) return (int'(last) + k) % 4;
    end
    return -1;
  endfunction

  task automatic load(input int i);
    m_din = req_din[16*i +: 16];
    m_bcd = req_bcd[i];
    m_dec = req_dec[2*i +: 2];
  endtask

  task automatic try_grant();
    int w;
    w = pick(req, m_id);
    if (w >= 0) begin
      m_id  = 2'(w);
      m_gnt = 4'b0001 << w;
      m_en  = 1'b1;
      held  = 0;
      load(w);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_gnt = 4'b0000; m_id = 2'd3; m_din = 16'h0000; m_bcd = 1'b1; m_dec = 2'd0;
      m_en = 1'b0; held = 0; blank_left = 0;
    end else if (m_en) begin
      held++;
      if (!req[m_id] || (held >= DWELL && (req & ~(4'b0001 << m_id)) != 4'b0000)) begin
        m_en = 1'b0; m_gnt = 4'b0000; blank_left = BLANK;
      end else begin
        load(int'(m_id));
      end
    end else if (blank_left > 0) begin
      blank_left--;
      if (blank_left == 0) try_grant();
    end else begin
      try_grant();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt",    32'(gnt),    32'(m_gnt));
    check("cur_id", 32'(cur_id), 32'(m_id));
    check("din",    32'(din),    32'(m_din));
    check("bcd",    32'(bcd),    32'(m_bcd));
    check("dec",    32'(dec),    32'(m_dec));
    check("enable", 32'(enable), 32'(m_en));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"},    32'(gnt),    32'h0);
    check({tag, "_enable"}, 32'(enable), 32'h0);
    check({tag, "_din"},    32'(din),    32'h0);
    check({tag, "_bcd"},    32'(bcd),    32'h1);
    check({tag, "_dec"},    32'(dec),    32'h0);
    check({tag, "_cur_id"}, 32'(cur_id), 32'h3);
  endtask

  task automatic set_client(input int i, input logic [15:0] v, input logic b, input logic [1:0] d);
    req_din[16*i +: 16] = v;
    req_bcd[i]          = b;
    req_dec[2*i +: 2]   = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  prev;
    logic [15:0] saved_din;
    int hi, gap, n_gr;

    rst = 1'b1; req = 4'b0000; req_din = '0; req_bcd = '0; req_dec = '0;
    m_gnt = 4'b0000; m_id = 2'd3; m_din = 16'h0; m_bcd = 1'b1; m_dec = 2'd0;
    m_en = 1'b0; held = 0; blank_left = 0;
    #2;

    // Reset state
    step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Sole requester (client 2) gets the display next cycle and keeps it
    set_client(2, 16'h1234, 1'b0, 2'd2);
    req = 4'b0100;
    step();
    check("t1_gnt", 32'(gnt), 32'h4);
    check("t1_id",  32'(cur_id), 32'h2);
    check("t1_din", 32'(din), 32'h1234);
    check("t1_bcd", 32'(bcd), 32'h0);
    check("t1_dec", 32'(dec), 32'h2);
    check("t1_en",  32'(enable), 32'h1);
    repeat (100) step();
    check("t1_hold_gnt", 32'(gnt), 32'h4);

    // All four request: order 0,1,2,3,0 with 8-cycle grants and 2-cycle gaps
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b1111;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    prev = 4'b0000; hi = 0; gap = 0; n_gr = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (gnt != 4'b0000) begin
        if (prev == 4'b0000) begin
          if (n_gr > 0) check("t2_gap", 32'(gap), 32'(BLANK));
          if (exp_q.size() > 0) check("t2_order", 32'(cur_id), 32'(exp_q.pop_front()));
          n_gr++;
          hi = 0;
        end
        hi++;
      end else begin
        if (prev != 4'b0000) begin
          check("t2_hold", 32'(hi), 32'(DWELL));
          gap = 0;
        end
        gap++;
      end
      prev = gnt;
    end
    check("t2_order_left", 32'(exp_q.size()), 32'h0);

    // Owner release before dwell expires
    do_reset();
    set_client(1, 16'h0777, 1'b1, 2'd1);
    req = 4'b0010;
    step();
    check("t3_gnt", 32'(gnt), 32'h2);
    repeat (3) step();
    req = 4'b0000;
    step();
    check("t3_rel_gnt", 32'(gnt), 32'h0);
    check("t3_rel_en",  32'(enable), 32'h0);
    repeat (2) step();
    step();
    check("t3_idle_en", 32'(enable), 32'h0);
    check("t3_idle_id", 32'(cur_id), 32'h1);

    // Live data change while showing
    do_reset();
    set_client(0, 16'h0001, 1'b1, 2'd0);
    req = 4'b0001;
    step();
    repeat (3) step();
    set_client(0, 16'h0042, 1'b1, 2'd0);
    step();
    check("t4_din", 32'(din), 32'h0042);
    check("t4_gnt", 32'(gnt), 32'h1);
    check("t4_en",  32'(enable), 32'h1);

    // Preemption: req[3] raised during client 0's second grant cycle
    do_reset();
    set_client(0, 16'h00A5, 1'b1, 2'd1);
    set_client(3, 16'hBEEF, 1'b0, 2'd3);
    req = 4'b0001;
    step();
    step();
    req = 4'b1001;
    hi = 2;
    for (int c = 0; c < 20; c++) begin
      step();
      if (gnt == 4'b0001) hi++;
      else break;
    end
    check("t5_hold", 32'(hi), 32'(DWELL));
    check("t5_blank_din", 32'(din), 32'h00A5);
    check("t5_blank_dec", 32'(dec), 32'h1);
    step();
    check("t5_blank_en", 32'(enable), 32'h0);
    check("t5_blank_din2", 32'(din), 32'h00A5);
    step();
    check("t5_next_gnt", 32'(gnt), 32'h8);
    check("t5_next_din", 32'(din), 32'hBEEF);

    // Reset in SHOW, then in BLANK; afterwards client 1 wins against client 3
    do_reset();
    req = 4'b0001;
    step();
    step();
    rst = 1'b1;
    step();
    check_reset_values("t6_show");
    rst = 1'b0;
    step();
    step();
    req = 4'b0000;
    step();
    check("t6_in_blank", 32'(enable), 32'h0);
    rst = 1'b1;
    step();
    check_reset_values("t6_blank");
    rst = 1'b0;
    req = 4'b1010;
    set_client(1, 16'h5A5A, 1'b0, 2'd3);
    step();
    check("t6_win_id",  32'(cur_id), 32'h1);
    check("t6_win_gnt", 32'(gnt), 32'h2);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) < 2) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        req_din = {$urandom, $urandom};
        req_bcd = 4'($urandom_range(0, 15));
        req_dec = 8'($urandom_range(0, 255));
      end
      step();
      check("rand_onehot", 32'($onehot0(gnt)), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
